// File: rtl/ex_mdu_stage_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, divider state codes and op-decode helpers.
package ex_mdu_stage_pkg;

    localparam int MDU_OP_BUS_W = 3;
    localparam int DIV_CNT_LEN  = 6;

    typedef enum logic [2:0] {
        MDU_NONE    = 3'd0,
        MDU_MUL_W   = 3'd1,
        MDU_MULH_W  = 3'd2,
        MDU_MULH_WU = 3'd3,
        MDU_DIV_W   = 3'd4,
        MDU_MOD_W   = 3'd5,
        MDU_DIV_WU  = 3'd6,
        MDU_MOD_WU  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Divide family occupies the upper half of the encoding space.
    function automatic logic is_div_op(input logic [MDU_OP_BUS_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_div(input logic [MDU_OP_BUS_W-1:0] op);
        return op[2] & ~op[1];
    endfunction

endpackage

// File: rtl/ex_mdu_stage_div_iter_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, MSB first.
// Results stay in the registers after completion until the next start.
module ex_mdu_stage_div_iter_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic              run_q, run_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W:0]   shifted_s;
    logic [DATA_W:0]   trial_s;
    logic              ge_s;

    assign shifted_s = {rem_q, quo_q[DATA_W-1]};
    assign trial_s   = shifted_s - {1'b0, dsr_q};
    assign ge_s      = ~trial_s[DATA_W];

    // Next-state for the iteration registers; a zero divisor naturally yields all-ones / dividend.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        if (kill_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            quo_d = dividend_i;
            rem_d = '0;
            dsr_d = divisor_i;
        end else if (run_q) begin
            quo_d = {quo_q[DATA_W-2:0], ge_s};
            rem_d = ge_s ? trial_s[DATA_W-1:0] : shifted_s[DATA_W-1:0];
            if (cnt_q == LAST_CNT) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end

    assign done_o      = run_q & (cnt_q == LAST_CNT);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_mdu_stage.sv
// Execute-stage MDU: single-cycle multiplies, iterative divides, result muxing
// and the ready_go/allowin handshake toward EX_MEM.
module ex_mdu_stage
    import ex_mdu_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  logic [2:0]        mdu_op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              flush_i,
    input  logic              mem_allowin_i,
    output logic              ex_allowin_o,
    output logic              ex_to_mem_valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              busy_o
);

    div_state_e state_q, state_d;

    logic              div_op_s, signed_op_s, start_s, ready_go_s, core_done_s;
    logic              is_mod_q, q_neg_q, r_neg_q, dz_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] dividend_s, divisor_s, quo_s, rem_s, quo_fix_s, rem_fix_s;
    logic              ext_a_s, ext_b_s;
    logic [2*DATA_W-1:0] mul_a_s, mul_b_s, prod_s;

    assign div_op_s    = is_div_op(mdu_op_i);
    assign signed_op_s = is_signed_div(mdu_op_i);
    assign start_s     = (state_q == ST_IDLE) & ex_valid_i & div_op_s & ~flush_i;
    assign ready_go_s  = ~div_op_s | (state_q == ST_DONE);

    assign ex_to_mem_valid_o = ex_valid_i & ready_go_s & ~flush_i;
    assign ex_allowin_o      = ~ex_valid_i | flush_i | (ready_go_s & mem_allowin_i);
    assign busy_o            = (state_q == ST_RUN) | (state_q == ST_DONE);

    assign dividend_s = (signed_op_s & src1_i[DATA_W-1]) ? (DATA_W'(0) - src1_i) : src1_i;
    assign divisor_s  = (signed_op_s & src2_i[DATA_W-1]) ? (DATA_W'(0) - src2_i) : src2_i;

    ex_mdu_stage_div_iter_core #(
        .DATA_W (DATA_W)
    ) u_div_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_s),
        .kill_i      (flush_i),
        .dividend_i  (dividend_s),
        .divisor_i   (divisor_s),
        .done_o      (core_done_s),
        .quotient_o  (quo_s),
        .remainder_o (rem_s)
    );

    // Divider FSM next-state; flush wins from every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = start_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = core_done_s ? ST_DONE : ST_RUN;
            ST_DONE: state_d = mem_allowin_i ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // FSM state register plus the sign/op context captured at divide start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            is_mod_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            src1_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_s) begin
                is_mod_q <= mdu_op_i[0];
                q_neg_q  <= signed_op_s & (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
                r_neg_q  <= signed_op_s & src1_i[DATA_W-1];
                dz_q     <= (src2_i == '0);
                src1_q   <= src1_i;
            end else begin
                is_mod_q <= is_mod_q;
                q_neg_q  <= q_neg_q;
                r_neg_q  <= r_neg_q;
                dz_q     <= dz_q;
                src1_q   <= src1_q;
            end
        end
    end

    // Divide-by-zero overrides the signed fix so the remainder is the untouched dividend.
    assign quo_fix_s = dz_q ? '1     : (q_neg_q ? (DATA_W'(0) - quo_s) : quo_s);
    assign rem_fix_s = dz_q ? src1_q : (r_neg_q ? (DATA_W'(0) - rem_s) : rem_s);

    // Extending both operands to 2*DATA_W makes one multiplier serve signed and unsigned high halves.
    assign ext_a_s = (mdu_op_i == MDU_MULH_W) & src1_i[DATA_W-1];
    assign ext_b_s = (mdu_op_i == MDU_MULH_W) & src2_i[DATA_W-1];
    assign mul_a_s = {{DATA_W{ext_a_s}}, src1_i};
    assign mul_b_s = {{DATA_W{ext_b_s}}, src2_i};
    assign prod_s  = mul_a_s * mul_b_s;

    // Result mux toward EX_MEM.
    always_comb begin
        result_o = '0;
        case (mdu_op_i)
            MDU_NONE:    result_o = alu_result_i;
            MDU_MUL_W:   result_o = prod_s[DATA_W-1:0];
            MDU_MULH_W:  result_o = prod_s[2*DATA_W-1:DATA_W];
            MDU_MULH_WU: result_o = prod_s[2*DATA_W-1:DATA_W];
            default: begin
                if (state_q == ST_DONE) begin
                    result_o = is_mod_q ? rem_fix_s : quo_fix_s;
                end else begin
                    result_o = '0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Self-checking bench for ex_mdu_stage: directed and random multiplies/divides
// compared against an arithmetic reference, plus latency, backpressure, flush and reset.
module tb_ex_mdu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic [2:0]  mdu_op_i;
    logic [31:0] src1_i, src2_i, alu_result_i;
    logic        flush_i, mem_allowin_i;
    logic        ex_allowin_o, ex_to_mem_valid_o, busy_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    ex_mdu_stage #(.DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_valid_i        (ex_valid_i),
        .mdu_op_i          (mdu_op_i),
        .src1_i            (src1_i),
        .src2_i            (src2_i),
        .alu_result_i      (alu_result_i),
        .flush_i           (flush_i),
        .mem_allowin_i     (mem_allowin_i),
        .ex_allowin_o      (ex_allowin_o),
        .ex_to_mem_valid_o (ex_to_mem_valid_o),
        .result_o          (result_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic with the architectural special cases.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] alu);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: return alu;
            3'd1: begin p = 64'(sa * sb); return p[31:0]; end
            3'd2: begin p = 64'(sa * sb); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            3'd6: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; ex_valid_i = 1'b0; mdu_op_i = 3'd0; src1_i = 32'd0; src2_i = 32'd0;
        alu_result_i = 32'd0; flush_i = 1'b0; mem_allowin_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (ex_to_mem_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_to_mem_valid_o); end
        checks++; if (ex_allowin_o !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", ex_allowin_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic mul_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [31:0] exp;
        ex_valid_i = 1'b1; mdu_op_i = op; src1_i = a; src2_i = b;
        alu_result_i = $urandom; mem_allowin_i = 1'b1;
        exp = model(op, a, b, alu_result_i);
        @(negedge clk);
        checks++; if (result_o !== exp) begin failures++; $display("FAIL %s result got=%h exp=%h", nm, result_o, exp); end
        checks++; if (ex_to_mem_valid_o !== 1'b1) begin failures++; $display("FAIL %s valid got=%b exp=1", nm, ex_to_mem_valid_o); end
        checks++; if (ex_allowin_o !== 1'b1) begin failures++; $display("FAIL %s allowin got=%b exp=1", nm, ex_allowin_o); end
        @(posedge clk); #1;
        ex_valid_i = 1'b0; mdu_op_i = 3'd0;
    endtask

    task automatic test_mul();
        mul_one(3'd1, 32'd7, 32'hFFFF_FFFD, "mul_w_dir");
        mul_one(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_wu_dir");
        mul_one(3'd2, 32'h8000_0000, 32'h8000_0000, "mulh_w_min");
        for (int i = 0; i < 16; i++) begin
            mul_one(3'($urandom_range(0, 3)), $urandom, $urandom, "mul_rand");
        end
    endtask

    // Starts a divide in the current cycle; returns one edge after it is accepted.
    task automatic do_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string nm);
        logic [31:0] exp;
        int k;
        bit done;
        ex_valid_i = 1'b1; mdu_op_i = op; src1_i = a; src2_i = b; flush_i = 1'b0;
        mem_allowin_i = (hold == 0);
        exp = model(op, a, b, 32'd0);
        k = 0; done = 0;
        while (!done && k <= 40) begin
            @(negedge clk);
            if (ex_to_mem_valid_o) begin
                done = 1;
            end else begin
                checks++; if (ex_allowin_o !== 1'b0) begin failures++; $display("FAIL %s allowin_run k=%0d got=%b exp=0", nm, k, ex_allowin_o); end
                checks++; if (busy_o !== (k > 0)) begin failures++; $display("FAIL %s busy_run k=%0d got=%b exp=%b", nm, k, busy_o, k > 0); end
                if (k == 1) begin src1_i = $urandom; src2_i = $urandom; end
                k++;
            end
        end
        checks++; if (!done || k != 33) begin failures++; $display("FAIL %s latency got=%0d exp=33 done=%0d", nm, k, done); end
        checks++; if (result_o !== exp) begin failures++; $display("FAIL %s result got=%h exp=%h", nm, result_o, exp); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++; if (ex_to_mem_valid_o !== 1'b1 || busy_o !== 1'b1 || ex_allowin_o !== 1'b0)
                begin failures++; $display("FAIL %s hold%0d valid=%b busy=%b allowin=%b exp=1,1,0", nm, i, ex_to_mem_valid_o, busy_o, ex_allowin_o); end
            checks++; if (result_o !== exp) begin failures++; $display("FAIL %s hold_result got=%h exp=%h", nm, result_o, exp); end
        end
        mem_allowin_i = 1'b1;
        #1;
        checks++; if (ex_allowin_o !== 1'b1) begin failures++; $display("FAIL %s allowin_accept got=%b exp=1", nm, ex_allowin_o); end
        @(posedge clk); #1;
        ex_valid_i = 1'b0; mdu_op_i = 3'd0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL %s idle_after got=%b exp=0", nm, busy_o); end
        if (!done) begin
            flush_i = 1'b1; @(posedge clk); #1; flush_i = 1'b0;
        end
    endtask

    task automatic test_div_dir();
        do_div(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_w_neg");
        do_div(3'd5, 32'hFFFF_FFF9, 32'd2, 0, "mod_w_neg");
        do_div(3'd6, 32'h1234_5678, 32'd0, 0, "div_wu_zero");
        do_div(3'd7, 32'h1234_5678, 32'd0, 0, "mod_wu_zero");
        do_div(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_w_ovf");
        do_div(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0, "mod_w_ovf");
        do_div(3'd5, 32'hFFFF_FFF9, 32'd0, 0, "mod_w_zero");
    endtask

    task automatic test_back_to_back();
        do_div(3'd6, 32'd100, 32'd7, 5, "div_wu_hold");
        do_div(3'd7, 32'd100, 32'd7, 0, "mod_wu_b2b");
    endtask

    task automatic test_div_rand();
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 50));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: b = $urandom;
            endcase
            do_div(3'($urandom_range(4, 7)), $urandom, b, $urandom_range(0, 2), "div_rand");
        end
    endtask

    task automatic test_flush();
        ex_valid_i = 1'b1; mdu_op_i = 3'd6; src1_i = $urandom; src2_i = $urandom | 32'd1;
        mem_allowin_i = 1'b1;
        repeat (12) @(negedge clk);
        flush_i = 1'b1;
        #1;
        checks++; if (ex_to_mem_valid_o !== 1'b0 || ex_allowin_o !== 1'b1 || busy_o !== 1'b1)
            begin failures++; $display("FAIL flush_run valid=%b allowin=%b busy=%b exp=0,1,1", ex_to_mem_valid_o, ex_allowin_o, busy_o); end
        @(posedge clk); #1;
        flush_i = 1'b0; ex_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_idle busy got=%b exp=0", busy_o); end
        ex_valid_i = 1'b1; mdu_op_i = 3'd4; flush_i = 1'b1;
        @(negedge clk);
        checks++; if (ex_to_mem_valid_o !== 1'b0 || ex_allowin_o !== 1'b1)
            begin failures++; $display("FAIL flush_idle_start valid=%b allowin=%b exp=0,1", ex_to_mem_valid_o, ex_allowin_o); end
        @(posedge clk); #1;
        flush_i = 1'b0; ex_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_nostart busy got=%b exp=0", busy_o); end
        do_div(3'd6, 32'd9, 32'd3, 0, "div_after_flush");
    endtask

    task automatic test_reset_mid_run();
        ex_valid_i = 1'b1; mdu_op_i = 3'd4; src1_i = $urandom; src2_i = $urandom | 32'd1;
        mem_allowin_i = 1'b1;
        repeat (22) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_mid_prebusy got=%b exp=1", busy_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || ex_to_mem_valid_o !== 1'b0)
            begin failures++; $display("FAIL rst_mid busy=%b valid=%b exp=0,0", busy_o, ex_to_mem_valid_o); end
        ex_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mul_one(3'd1, 32'd3, 32'd4, "mul_after_rst");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_dir();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_div_rand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mdu_stage.md
Name: ex_mdu_stage

Overview:
- Execute-stage multiply/divide unit. It sits between the ID_EX pipeline register and the EX_MEM pipeline register.
- Multiplies complete in one cycle. Divides use an iterative radix-2 divider.
- It generates the ready_go/allowin handshake so that the EX_MEM register latches the result only when it is final.
- Non-MDU instructions pass the ALU result through with zero added latency.

Parameters:
- DATA_W, 32, operand/result width (the divider counter width is clog2(DATA_W)+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ex_valid_i  in  1  EX stage holds a valid instruction (from ID_EX)
- mdu_op_i  in  3  0 NONE, 1 MUL_W, 2 MULH_W, 3 MULH_WU, 4 DIV_W, 5 MOD_W, 6 DIV_WU, 7 MOD_WU
- src1_i  in  32  rj operand
- src2_i  in  32  rk operand
- alu_result_i  in  32  ALU result, used when op is NONE
- flush_i  in  1  exception/ertn flush; kills the EX instruction
- mem_allowin_i  in  1  EX_MEM/MEM can accept
- ex_allowin_o  out  1  ID_EX may load a new instruction
- ex_to_mem_valid_o  out  1  EX output is valid for EX_MEM
- result_o  out  32  final result toward EX_MEM
- busy_o  out  1  divider in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE, plus a 6-bit counter cnt. Async reset sets state=IDLE, cnt=0, quotient/remainder/operand regs=0, busy_o=0.
- ready_go:
  - 1 when op is 0..3.
  - For a div op (4..7), 1 only when state==DONE.
- ex_to_mem_valid_o = ex_valid_i & ready_go & !flush_i.
- ex_allowin_o = !ex_valid_i | flush_i | (ready_go & mem_allowin_i).
- IDLE -> RUN: on an edge with ex_valid_i & div op & !flush_i.
  - Latch |src1|, |src2| (absolute value only for DIV_W/MOD_W), quotient and remainder signs, the op, and a div-by-zero flag.
  - cnt=0.
- RUN: one restoring-division step per cycle, producing one quotient bit MSB first. At the edge where cnt==31, go to DONE. Otherwise cnt++.
- DONE:
  - Apply the sign fix. Quotient is negated if dividend and divisor signs differ (signed ops only). Remainder takes the dividend sign.
  - Hold the result until an edge with mem_allowin_i=1, then go to IDLE.
- Div latency: start cycle T0 (IDLE, valid). DONE and ex_to_mem_valid_o=1 at T0+33.
- result_o (combinational):
  - NONE: alu_result_i.
  - MUL_W: low 32 bits of the product.
  - MULH_W: high 32 bits of the signed 64-bit product.
  - MULH_WU: high 32 bits of the unsigned 64-bit product.
  - Div op: fixed quotient/remainder when in DONE, else 0.
- Divide by zero:
  - Still takes the full 33 cycles.
  - Quotient = 0xFFFFFFFF and remainder = src1 (latched original), for signed and unsigned ops.
- Overflow: DIV_W 0x80000000 / 0xFFFFFFFF gives 0x80000000. MOD_W with the same operands gives 0.
- Backpressure: in DONE with mem_allowin_i=0, state, result and ex_to_mem_valid_o are held. ex_allowin_o=0.
- flush_i:
  - Forces state=IDLE and cnt=0 on the next edge from any state.
  - Same cycle: ex_to_mem_valid_o=0 and ex_allowin_o=1.
  - A div op seen in IDLE with flush_i=1 does not start.
- rst_n low mid-RUN: immediate IDLE and busy_o=0, asynchronously.
- Operands are latched at start. Changes on src*_i during RUN are ignored.
- Back-to-back divides: DONE accepted at edge E gives IDLE after E. The next div starts on the following edge, so there is no overlap.

Decomposition:
- Shared header DefineModuleBus.h gets:
  - MDU op encodings (MduOpBusWidth, the eight op codes).
  - DivCntLen.
  - FSM state codes.
- One natural sub-module, div_iter_core:
  - Unsigned restoring divider.
  - Inputs: start, dividend, divisor, kill.
  - Outputs: done, quotient, remainder.
- ex_mdu_stage keeps the sign handling, muxing and handshake.

Test Plan:
- MUL_W 7 x 0xFFFFFFFD with ex_valid_i=1, mem_allowin_i=1 -> same cycle result_o=0xFFFFFFEB, ex_to_mem_valid_o=1, ex_allowin_o=1. MULH_WU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV_W 0xFFFFFFF9 / 2 -> ex_to_mem_valid_o first high exactly 33 cycles after start, result 0xFFFFFFFD. MOD_W on the same operands -> 0xFFFFFFFF. ex_allowin_o=0 during cycles T0..T0+32.
- Edge values:
  - DIV_WU 0x12345678 / 0 -> 0xFFFFFFFF.
  - MOD_WU 0x12345678 / 0 -> 0x12345678.
  - DIV_W 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - MOD_W 0x80000000 / 0xFFFFFFFF -> 0.
- DIV_WU 100 / 7 reaches DONE with mem_allowin_i=0 for 5 cycles -> result 14 and valid held, busy_o=1. After release, accepted on one edge, then IDLE. A back-to-back MOD_WU 100 / 7 returns 2 after another 33 cycles.
- flush_i pulse at RUN cycle 10 -> next cycle IDLE, busy_o=0, no ex_to_mem_valid_o. A following DIV_WU 9 / 3 returns 3 with full latency.
- rst_n low for 1 cycle at RUN cycle 20 -> state IDLE immediately, busy_o=0, ex_to_mem_valid_o=0. After release, MUL_W 3 x 4 -> 12.
